// File: rtl/rd_req_dispatcher.sv
// rd_req_dispatcher: issues held READ requests one-hot to address-selected targets, with ack or timeout err
// ports: aclk/areset clock and async active-high reset; req/addr/cmd requester side;
//        ack/err one-cycle completion pulses; busy read outstanding;
//        t_req/t_addr/t_ack target side (one-hot request, captured address, per-target accept)
module rd_req_dispatcher #(
  parameter int AWIDTH    = 32,
  parameter int NTGT      = 2,
  parameter int TO_CYCLES = 255
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              req,
  input  logic [AWIDTH-1:0] addr,
  input  logic              cmd,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic [NTGT-1:0]   t_req,
  output logic [AWIDTH-1:0] t_addr,
  input  logic [NTGT-1:0]   t_ack
);
  localparam int SELW = $clog2(NTGT);
  localparam int CW = (TO_CYCLES < 1) ? 1 : $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TO_CYCLES > 0) ? TO_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, ARMED, ISSUE, WAIT_LOW} state_t;
  state_t state, state_n;
  logic [SELW-1:0] idx, idx_n, sel;
  logic [CW-1:0] cnt, cnt_n;
  logic ack_n, err_n, busy_n, take, hit, expired, stay;
  logic [NTGT-1:0] t_req_n;
  logic [AWIDTH-1:0] t_addr_n;
  assign sel = addr[AWIDTH-1 -: SELW];
  assign hit = t_ack[idx];
  assign expired = (TO_CYCLES > 0) && (cnt == TO_LAST);
  assign take = (state == ARMED) && req && cmd;
  // an accept beats a simultaneous timeout
  assign stay = (state == ISSUE) && !hit && !expired;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      ack    <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      t_req  <= '0;
      t_addr <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      ack    <= ack_n;
      err    <= err_n;
      busy   <= busy_n;
      t_req  <= t_req_n;
      t_addr <= t_addr_n;
    end
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     state_n = ARMED;
      ARMED:    state_n = req ? (cmd ? ISSUE : WAIT_LOW) : ARMED;
      ISSUE:    state_n = stay ? ISSUE : WAIT_LOW;
      WAIT_LOW: state_n = req ? WAIT_LOW : ARMED;
    endcase
  end
  always_comb begin
    idx_n    = take ? sel : idx;
    cnt_n    = take ? '0 : (stay && cnt != '1) ? cnt + 1'b1 : cnt;
    ack_n    = (state == ISSUE) && hit;
    err_n    = (state == ISSUE) && !hit && expired;
    busy_n   = take || stay;
    t_req_n  = take ? {{(NTGT-1){1'b0}}, 1'b1} << sel : stay ? t_req : '0;
    t_addr_n = take ? addr : stay ? t_addr : '0;
  end
endmodule

// File: tb/tb_rd_req_dispatcher.sv
// tb_rd_req_dispatcher: directed checks of rd_req_dispatcher with NTGT=4, TO_CYCLES=4
module tb_rd_req_dispatcher;
  logic aclk, areset, req, cmd, ack, err, busy;
  logic [31:0] addr, t_addr;
  logic [3:0] t_req, t_ack;
  int checks = 0;
  int failures = 0;
  int high, errs, acks;
  rd_req_dispatcher #(.AWIDTH(32), .NTGT(4), .TO_CYCLES(4)) dut (
    .aclk(aclk), .areset(areset), .req(req), .addr(addr), .cmd(cmd),
    .ack(ack), .err(err), .busy(busy), .t_req(t_req), .t_addr(t_addr), .t_ack(t_ack)
  );
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge aclk);
    #1;
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_treq"}, 64'(t_req), 64'h0);
    chk({tag, "_taddr"}, 64'(t_addr), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_ack"}, 64'(ack), 64'h0);
    chk({tag, "_err"}, 64'(err), 64'h0);
  endtask
  always @(negedge aclk) begin
    if (!areset) begin
      chk("ack_err_excl", 64'(ack & err), 64'h0);
      chk("treq_onehot", 64'($countones(t_req) <= 1), 64'h1);
    end
  end
  initial begin
    areset = 1'b1;
    req = 1'b0;
    cmd = 1'b0;
    addr = '0;
    t_ack = '0;
    tick;
    tick;
    chk_quiet("rst");
    // read to target 3, accepted on the second ISSUE cycle
    areset = 1'b0;
    req = 1'b1;
    cmd = 1'b1;
    addr = 32'hC000_0010;
    tick;
    chk("first_edge_treq", 64'(t_req), 64'h0);
    tick;
    chk("issue_treq", 64'(t_req), 64'h8);
    chk("issue_taddr", 64'(t_addr), 64'hC000_0010);
    chk("issue_busy", 64'(busy), 64'h1);
    tick;
    chk("issue2_treq", 64'(t_req), 64'h8);
    chk("issue2_err", 64'(err), 64'h0);
    t_ack = 4'b1000;
    tick;
    chk("acc_ack", 64'(ack), 64'h1);
    chk("acc_err", 64'(err), 64'h0);
    chk("acc_treq", 64'(t_req), 64'h0);
    chk("acc_taddr", 64'(t_addr), 64'h0);
    chk("acc_busy", 64'(busy), 64'h0);
    req = 1'b0;
    t_ack = '0;
    tick;
    chk("acc_pulse", 64'(ack), 64'h0);
    // WRITE is ignored and a held req never turns into a read
    req = 1'b1;
    cmd = 1'b0;
    addr = 32'h4000_0000;
    tick;
    chk_quiet("wr");
    cmd = 1'b1;
    tick;
    tick;
    tick;
    chk_quiet("held");
    req = 1'b0;
    tick;
    // timeout to target 1 while a foreign t_ack is held
    req = 1'b1;
    t_ack = 4'b0001;
    tick;
    chk("to_treq", 64'(t_req), 64'h2);
    chk("to_taddr", 64'(t_addr), 64'h4000_0000);
    high = 1;
    errs = 0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (t_req != 0) high++;
      if (err) errs++;
      if (ack) acks++;
    end
    chk("to_high_cycles", 64'(high), 64'd4);
    chk("to_err_pulses", 64'(errs), 64'd1);
    chk("to_ack_pulses", 64'(acks), 64'd0);
    chk("to_busy", 64'(busy), 64'h0);
    req = 1'b0;
    t_ack = '0;
    tick;
    // accept in the last ISSUE cycle beats the timeout; addr/cmd changes ignored
    req = 1'b1;
    cmd = 1'b1;
    addr = 32'h8000_1234;
    tick;
    chk("late_treq", 64'(t_req), 64'h4);
    addr = 32'h0;
    cmd = 1'b0;
    tick;
    tick;
    tick;
    chk("late_taddr", 64'(t_addr), 64'h8000_1234);
    chk("late_treq4", 64'(t_req), 64'h4);
    chk("late_err_early", 64'(err), 64'h0);
    t_ack = 4'b0100;
    tick;
    chk("late_ack", 64'(ack), 64'h1);
    chk("late_err", 64'(err), 64'h0);
    chk("late_busy", 64'(busy), 64'h0);
    req = 1'b0;
    t_ack = '0;
    tick;
    chk("late_ack_pulse", 64'(ack), 64'h0);
    chk("late_err_after", 64'(err), 64'h0);
    // reset in the middle of ISSUE, then a fresh read
    req = 1'b1;
    cmd = 1'b1;
    addr = 32'h4000_00AA;
    tick;
    chk("mid_treq", 64'(t_req), 64'h2);
    #2;
    areset = 1'b1;
    #1;
    chk_quiet("mid_rst");
    tick;
    areset = 1'b0;
    tick;
    chk("post_rst_armed", 64'(t_req), 64'h0);
    tick;
    chk("post_rst_treq", 64'(t_req), 64'h2);
    chk("post_rst_taddr", 64'(t_addr), 64'h4000_00AA);
    t_ack = 4'b0010;
    tick;
    chk("post_rst_ack", 64'(ack), 64'h1);
    chk("post_rst_err", 64'(err), 64'h0);
    req = 1'b0;
    t_ack = '0;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rd_req_dispatcher.md
RD_REQ_DISPATCHER -- requirements
Module: rd_req_dispatcher

Interface
REQ-001 SHALL have parameter AWIDTH, default 32: address width in bits.
REQ-002 SHALL have parameter NTGT, default 2: number of target ports; a power of two, at least 2.
REQ-003 SHALL have parameter TO_CYCLES, default 255: ack timeout in cycles; 0 disables the timeout.
REQ-004 SHALL derive SELW = log2(NTGT) and CW = ceil(log2(TO_CYCLES+1)), with minimum 1.
REQ-005 aclk  in  1  single clock; all state updates on its rising edge.
REQ-006 areset  in  1  asynchronous, active-high reset.
REQ-007 req  in  1  requester strobe, level-held by the requester until it sees ack or err.
REQ-008 addr  in  AWIDTH  request address, valid while req=1.
REQ-009 cmd  in  1  1=READ, 0=WRITE; this block serves only READ.
REQ-010 ack  out  1  one-cycle pulse: target accepted the read.
REQ-011 err  out  1  one-cycle pulse: timeout, no target accept.
REQ-012 busy  out  1  high while a read is outstanding to a target.
REQ-013 t_req  out  NTGT  one-hot read request to the targets.
REQ-014 t_addr  out  AWIDTH  captured address to the targets.
REQ-015 t_ack  in  NTGT  per-target accept.

Function
REQ-016 SHALL compute the target index as addr[AWIDTH-1 -: SELW]; t_addr SHALL carry the full captured address unchanged.
REQ-017 SHALL implement FSM states IDLE, ARMED, ISSUE and WAIT_LOW, with IDLE as the reset state.
REQ-018 IDLE SHALL go to ARMED unconditionally after one cycle.
REQ-019 ARMED, req=1 and cmd=1: SHALL capture addr and the index, and go to ISSUE.
REQ-020 ARMED, req=1 and cmd=0: SHALL capture nothing, drive no output, and go to WAIT_LOW.
REQ-021 ARMED, req=0: SHALL stay in ARMED.
REQ-022 ISSUE SHALL drive t_req[idx]=1 and all other bits 0, hold t_addr, drive busy=1, and increment the timeout counter each cycle.
REQ-023 Latency: req and cmd sampled at edge k in ARMED SHALL make t_req, t_addr and busy valid from edge k (registered outputs).
REQ-024 In ISSUE, t_ack[idx]=1 sampled at edge m SHALL make ack=1 for exactly one cycle after m.
REQ-025 At the same edge m, t_req SHALL go to 0, t_addr to 0 and busy to 0, and the FSM SHALL go to WAIT_LOW.
REQ-026 t_ack bits other than idx SHALL be ignored, as SHALL any t_ack outside ISSUE.
REQ-027 Timeout: with TO_CYCLES>0, when the counter reaches TO_CYCLES-1 without an accept, SHALL pulse err for one cycle, clear t_req, t_addr and busy, and go to WAIT_LOW.
REQ-028 With TO_CYCLES=0, ISSUE SHALL wait indefinitely.
REQ-029 If t_ack[idx] and the timeout occur in the same cycle, the accept SHALL win: ack=1, err=0.
REQ-030 The timeout counter SHALL be CW bits wide, SHALL clear on entry to ISSUE, and SHALL never wrap.
REQ-031 WAIT_LOW, req=0: SHALL go to ARMED.
REQ-032 WAIT_LOW, req=1: SHALL stay, so a held req issues exactly one transaction.
REQ-033 ack and err SHALL never both be 1.
REQ-034 t_req SHALL be all-zero or one-hot in every cycle.
REQ-035 Changes on addr and cmd while in ISSUE or WAIT_LOW SHALL have no effect.

Reset
REQ-036 areset=1 SHALL immediately force: state IDLE, t_req=0, t_addr=0, ack=0, err=0, busy=0, counter=0.
REQ-037 This SHALL hold even mid-ISSUE; the outstanding request is dropped with no ack and no err.
REQ-038 After areset falls, the first request SHALL be accepted no earlier than the second rising edge (IDLE -> ARMED).

Verification
REQ-039 NTGT=4, addr=0xC000_0010, cmd=1, req=1, t_ack[3]=1 two cycles later -> t_req=4'b1000 and t_addr=0xC000_0010 for 2 cycles, then one ack pulse, no err.
REQ-040 NTGT=2, req=1 with cmd=0 -> t_req stays 0, no ack or err; the same req held then changed to cmd=1 without dropping -> still no issue until req drops and rises again.
REQ-041 TO_CYCLES=4, no t_ack -> t_req high exactly 4 cycles, one err pulse, busy low afterwards.
REQ-042 TO_CYCLES=4, t_ack[idx] arrives in the 4th ISSUE cycle -> ack=1, err=0.
REQ-043 idx=1, t_ack[0] held at 1 throughout -> ignored; result is a timeout err.
REQ-044 areset pulsed during ISSUE -> all outputs 0 immediately; after release, a new read completes normally.
